// File: rtl/mc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mc_pkg
// Purpose  : Shared encodings for the multicycle MIPS controller: FSM state
//            enum, ALU control codes, opcodes, funct codes, ALU operand and
//            next-PC select encodings, and the aluop encoding used between
//            the FSM and the ALU decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_e;

  // ALU control codes
  localparam logic [3:0] c_alu_and = 4'b0000;
  localparam logic [3:0] c_alu_or  = 4'b0001;
  localparam logic [3:0] c_alu_add = 4'b0010;
  localparam logic [3:0] c_alu_sub = 4'b0110;
  localparam logic [3:0] c_alu_slt = 4'b0111;
  localparam logic [3:0] c_alu_sll = 4'b1000;

  // Opcodes (instr[31:26])
  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_addi  = 6'b001000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  // Funct codes (instr[5:0])
  localparam logic [5:0] c_fn_sll = 6'b000000;
  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_slt = 6'b101010;

  // ALU B operand select
  localparam logic [1:0] c_srcb_regb  = 2'b00;
  localparam logic [1:0] c_srcb_four  = 2'b01;
  localparam logic [1:0] c_srcb_imm   = 2'b10;
  localparam logic [1:0] c_srcb_immsh = 2'b11;

  // Next-PC select
  localparam logic [1:0] c_pcsrc_alures = 2'b00;
  localparam logic [1:0] c_pcsrc_aluout = 2'b01;
  localparam logic [1:0] c_pcsrc_jump   = 2'b10;

  // FSM -> ALU decoder operation class
  localparam logic [1:0] c_aluop_add   = 2'b00;
  localparam logic [1:0] c_aluop_sub   = 2'b01;
  localparam logic [1:0] c_aluop_funct = 2'b10;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/aludec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : aludec
// Purpose  : Combinational ALU decoder. Selects add, subtract or a
//            funct-field decode according to the FSM's aluop.
// Ports    : funct_i      [5:0] instruction funct field
//            aluop_i      [1:0] operation class from the FSM
//            alucontrol_o [3:0] ALU operation code
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct_i,
  input  logic [1:0] aluop_i,
  output logic [3:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = c_alu_add;
    case (aluop_i)
      c_aluop_sub: alucontrol_o = c_alu_sub;
      c_aluop_funct: begin
        // Unknown funct codes fall back to ADD; the write-back still happens.
        case (funct_i)
          c_fn_add: alucontrol_o = c_alu_add;
          c_fn_sub: alucontrol_o = c_alu_sub;
          c_fn_and: alucontrol_o = c_alu_and;
          c_fn_or:  alucontrol_o = c_alu_or;
          c_fn_slt: alucontrol_o = c_alu_slt;
          c_fn_sll: alucontrol_o = c_alu_sll;
          default:  alucontrol_o = c_alu_add;
        endcase
      end
      default: alucontrol_o = c_alu_add;
    endcase
  end

endmodule : aludec
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : mc_controller
// Purpose  : Moore-FSM control unit for a multicycle MIPS datapath
//            (lw, sw, R-type, beq, addi, j).
// Ports    : clk, reset_n (async active-low)
//            op[5:0], funct[5:0], zero         - instruction fields, ALU flag
//            iord, memwrite, irwrite, regdst,
//            memtoreg, regwrite, alusrca       - datapath controls
//            alusrcb[1:0], pcsrc[1:0]          - operand / next-PC selects
//            pcen                              - PC load enable
//            alucontrol[3:0]                   - ALU operation
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] alucontrol
);

  state_e     state_q;
  state_e     state_d;

  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_memwrite;
  logic [1:0] w_aluop;

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          c_op_lw, c_op_sw: state_d = S_MEMADR;
          c_op_rtype:       state_d = S_RTYPEEX;
          c_op_beq:         state_d = S_BEQEX;
          c_op_addi:        state_d = S_ADDIEX;
          c_op_j:           state_d = S_JEX;
          default:          state_d = S_FETCH;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything but sw is a load.
      S_MEMADR:  state_d = (op == c_op_sw) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Moore output decode
  always_comb begin
    iord       = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = c_srcb_regb;
    pcsrc      = c_pcsrc_alures;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_aluop    = c_aluop_add;
    case (state_q)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb   = c_srcb_four;
      end
      S_DECODE: alusrcb = c_srcb_immsh;
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = c_srcb_imm;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        memtoreg   = 1'b1;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = c_aluop_funct;
      end
      S_RTYPEWB: begin
        w_regwrite = 1'b1;
        regdst     = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        pcsrc    = c_pcsrc_aluout;
        w_branch = 1'b1;
        w_aluop  = c_aluop_sub;
      end
      S_JEX: begin
        w_pcwrite = 1'b1;
        pcsrc     = c_pcsrc_jump;
      end
      default: ;
    endcase
  end

  // State already sits in FETCH during reset; only the side-effecting
  // enables need masking so nothing is written while reset is held.
  assign irwrite  = w_irwrite  & reset_n;
  assign regwrite = w_regwrite & reset_n;
  assign memwrite = w_memwrite & reset_n;
  assign pcen     = (w_pcwrite | (w_branch & zero)) & reset_n;

  aludec u_aludec (
    .funct_i      (funct),
    .aluop_i      (w_aluop),
    .alucontrol_o (alucontrol)
  );

endmodule : mc_controller
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_mc_controller
// Purpose  : Scoreboard bench for mc_controller. The driver pushes the
//            hand-derived expected output vector for every cycle it drives;
//            the monitor pops and compares on each falling clock edge.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mc_controller;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol;

  mc_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side state labels
  localparam int T_F   = 0;
  localparam int T_D   = 1;
  localparam int T_MA  = 2;
  localparam int T_MR  = 3;
  localparam int T_MWB = 4;
  localparam int T_MWR = 5;
  localparam int T_RX  = 6;
  localparam int T_RW  = 7;
  localparam int T_BQ  = 8;
  localparam int T_AX  = 9;
  localparam int T_AW  = 10;
  localparam int T_J   = 11;
  localparam int T_RST = 12;

  typedef struct {
    logic [15:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Vector layout: iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
  //                alusrcb[2],pcsrc[2],pcen,alucontrol[4]
  function automatic logic [15:0] expv(input int st, input logic [3:0] alu,
                                       input logic pc_b);
    logic       e_iord, e_mw, e_irw, e_rd, e_mtr, e_rw, e_sa, e_pe;
    logic [1:0] e_sb, e_ps;
    logic [3:0] e_ac;
    e_iord = 0; e_mw = 0; e_irw = 0; e_rd = 0; e_mtr = 0; e_rw = 0; e_sa = 0;
    e_pe = 0; e_sb = 2'b00; e_ps = 2'b00; e_ac = 4'b0010;
    case (st)
      T_F:         begin e_irw = 1; e_pe = 1; e_sb = 2'b01; end
      T_D:         e_sb = 2'b11;
      T_MA, T_AX:  begin e_sa = 1; e_sb = 2'b10; end
      T_MR:        e_iord = 1;
      T_MWR:       begin e_iord = 1; e_mw = 1; end
      T_MWB:       begin e_rw = 1; e_mtr = 1; end
      T_AW:        e_rw = 1;
      T_RX:        begin e_sa = 1; e_ac = alu; end
      T_RW:        begin e_rw = 1; e_rd = 1; end
      T_BQ:        begin e_sa = 1; e_ps = 2'b01; e_ac = 4'b0110; e_pe = pc_b; end
      T_J:         begin e_pe = 1; e_ps = 2'b10; end
      T_RST:       e_sb = 2'b01;
      default:     ;
    endcase
    return {e_iord, e_mw, e_irw, e_rd, e_mtr, e_rw, e_sa, e_sb, e_ps, e_pe, e_ac};
  endfunction

  // Push one expected vector, then advance to 1 time unit past the next rise.
  task automatic cyc(input int st, input string nm,
                     input logic [3:0] alu = 4'b0010, input logic pc_b = 1'b0);
    exp_t e;
    e.v  = expv(st, alu, pc_b);
    e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_lw(input string tag);
    op = 6'b100011; funct = 6'b010101; zero = 1'b1;
    cyc(T_F,  {tag, "_fetch"});
    cyc(T_D,  {tag, "_decode"});
    cyc(T_MA, {tag, "_memadr"});
    op = 6'b101011; funct = 6'b101010;   // must not matter after MEMADR
    cyc(T_MR,  {tag, "_memrd"});
    cyc(T_MWB, {tag, "_memwb"});
  endtask

  task automatic run_rtype(input logic [5:0] fn, input logic [3:0] alu,
                           input string tag);
    op = 6'b000000; funct = fn; zero = 1'b1;
    cyc(T_F,  {tag, "_fetch"});
    cyc(T_D,  {tag, "_decode"});
    cyc(T_RX, {tag, "_rtypeex"}, alu);
    funct = 6'b100010;                   // must not matter in RTYPEWB
    cyc(T_RW, {tag, "_rtypewb"});
  endtask

  task automatic run_beq(input logic z, input string tag);
    op = 6'b000100; funct = 6'b000000; zero = z;
    cyc(T_F,  {tag, "_fetch"});
    cyc(T_D,  {tag, "_decode"});
    cyc(T_BQ, {tag, "_beqex"}, 4'b0110, z);
  endtask

  // Monitor: compare whenever the driver has an expectation outstanding.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [15:0] got;
      e   = q.pop_front();
      got = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
             alusrcb, pcsrc, pcen, alucontrol};
      vectors++;
      if (got !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b", e.nm, got, e.v);
      end
    end
  end

  // Driver
  initial begin
    reset_n = 1'b0; op = 6'b100011; funct = 6'b0; zero = 1'b1;
    @(posedge clk); #1;
    cyc(T_RST, "reset_hold0");
    cyc(T_RST, "reset_hold1");
    reset_n = 1'b1;

    run_lw("lw1");

    op = 6'b101011; funct = 6'b0; zero = 1'b1;
    cyc(T_F,   "sw_fetch");
    cyc(T_D,   "sw_decode");
    cyc(T_MA,  "sw_memadr");
    op = 6'b100011;
    cyc(T_MWR, "sw_memwr");

    run_rtype(6'b101010, 4'b0111, "slt");
    run_rtype(6'b000000, 4'b1000, "sll");
    run_rtype(6'b100000, 4'b0010, "add");
    run_rtype(6'b100010, 4'b0110, "sub");
    run_rtype(6'b100100, 4'b0000, "and");
    run_rtype(6'b100101, 4'b0001, "or");
    run_rtype(6'b111111, 4'b0010, "badfn");

    run_beq(1'b1, "beq_taken");
    run_beq(1'b0, "beq_nottaken");

    op = 6'b001000; zero = 1'b1;
    cyc(T_F,  "addi_fetch");
    cyc(T_D,  "addi_decode");
    cyc(T_AX, "addi_ex");
    cyc(T_AW, "addi_wb");

    op = 6'b000010;
    cyc(T_F, "j_fetch");
    cyc(T_D, "j_decode");
    cyc(T_J, "j_ex");

    op = 6'b111111;
    cyc(T_F, "ill_fetch");
    cyc(T_D, "ill_decode");

    // lw interrupted by reset while in MEMRD: reset lands between edges,
    // so the check before the next rise shows the asynchronous effect.
    op = 6'b100011; zero = 1'b1;
    cyc(T_F,  "lwr_fetch");
    cyc(T_D,  "lwr_decode");
    cyc(T_MA, "lwr_memadr");
    reset_n = 1'b0;
    cyc(T_RST, "lwr_async_reset");
    cyc(T_RST, "lwr_reset_hold");
    reset_n = 1'b1;

    run_lw("lw2");
    cyc(T_F, "final_fetch");

    #10;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mc_controller
`default_nettype wire
